soc_system_command: RTL and testbench

Avalon-MM slave that carries HPS commands into the fabric. It is the write-direction counterpart of the read-only PIO input port.
- HPS writes 32-bit command words into a small FIFO.
- The block presents them downstream on a valid/ready stream, feeding the graphics/command processor.
- Status, flush and a delivered-word counter are readable through the same 4-word register window.

---
 rtl/soc_cmd_pkg.sv | 18 +
 rtl/soc_system_command_fifo.sv | 54 +++++
 rtl/soc_system_command.sv | 124 ++++++++++++
 tb/tb_soc_system_command.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/soc_cmd_pkg.sv
// rtl/soc_cmd_pkg.sv - register map constants for the HPS command queue
package soc_cmd_pkg;

    localparam logic [1:0] ADDR_CMD       = 2'd0;
    localparam logic [1:0] ADDR_STATUS    = 2'd1;
    localparam logic [1:0] ADDR_CTRL      = 2'd2;
    localparam logic [1:0] ADDR_DELIVERED = 2'd3;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    localparam int CTRL_FLUSH    = 0;
    localparam int CTRL_IE_EMPTY = 8;
    localparam int CTRL_IE_OVF   = 9;

endpackage

// File: rtl/soc_system_command_fifo.sv
// rtl/soc_system_command_fifo.sv - show-ahead command FIFO with single-cycle flush
module soc_system_command_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full/empty come from the occupancy counter so wrapped pointers never alias.
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/soc_system_command.sv
// rtl/soc_system_command.sv - Avalon-MM command FIFO to stream bridge; SOC_CMD_IRQ_EN adds irq
module soc_system_command
    import soc_cmd_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SOC_CMD_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              wr_en;
    logic              push;
    logic              flush;
    logic              xfer;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [31:0]       delivered;
    logic [DATA_W-1:0] last_cmd;
    logic [DATA_W-1:0] rdata_next;
    logic              ie_empty;
    logic              ie_ovf;

    assign wr_en     = chipselect & ~write_n;
    assign push      = wr_en & (address == ADDR_CMD);
    assign flush     = wr_en & (address == ADDR_CTRL) & writedata[CTRL_FLUSH];
    assign out_valid = ~empty;
    assign xfer      = out_valid & out_ready;

    soc_system_command_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (out_ready),
        .flush   (flush),
        .din     (writedata),
        .dout    (out_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            delivered <= '0;
            last_cmd  <= '0;
        end else begin
            if (push) last_cmd <= writedata;
            // A push into a full FIFO survives only if the head leaves this cycle.
            if (push & full & ~xfer)
                overflow <= 1'b1;
            else if (wr_en & (address == ADDR_STATUS) & writedata[ST_OVF])
                overflow <= 1'b0;
            if (wr_en & (address == ADDR_DELIVERED))
                delivered <= '0;
            else if (xfer)
                delivered <= delivered + 32'd1;
        end
    end

`ifdef SOC_CMD_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_empty <= 1'b0;
            ie_ovf   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_en & (address == ADDR_CTRL)) begin
                ie_empty <= writedata[CTRL_IE_EMPTY];
                ie_ovf   <= writedata[CTRL_IE_OVF];
            end
            irq <= (ie_empty & empty) | (ie_ovf & overflow);
        end
    end
`else
    assign ie_empty = 1'b0;
    assign ie_ovf   = 1'b0;
`endif

    always_comb begin
        rdata_next = '0;
        case (address)
            ADDR_CMD: rdata_next = last_cmd;
            ADDR_STATUS: begin
                rdata_next[ST_EMPTY]               = empty;
                rdata_next[ST_FULL]                = full;
                rdata_next[ST_OVF]                 = overflow;
                rdata_next[ST_CNT_LSB +: CNT_W]    = count;
            end
            ADDR_CTRL: begin
                rdata_next[CTRL_IE_EMPTY] = ie_empty;
                rdata_next[CTRL_IE_OVF]   = ie_ovf;
            end
            default: rdata_next = DATA_W'(delivered);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rdata_next;
    end

endmodule

// File: tb/tb_soc_system_command.sv
// tb/tb_soc_system_command.sv - directed bench for soc_system_command (honours SOC_CMD_IRQ_EN)
module tb_soc_system_command;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef SOC_CMD_IRQ_EN
    logic        irq;
`endif

    int passed = 0;
    int total  = 0;

    soc_system_command dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef SOC_CMD_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        step();
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_words [4];

        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; out_ready = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        read_check("rst_cmd", 2'd0, 32'h0);
        read_check("rst_status", 2'd1, 32'h1);
        read_check("rst_ctrl", 2'd2, 32'h0);
        read_check("rst_delivered", 2'd3, 32'h0);

        // Fill, then overflow.
        for (int i = 1; i <= 4; i++) bus_write(2'd0, 32'hA000_0000 + 32'(i));
        read_check("full_status", 2'd1, 32'h42);
        bus_write(2'd0, 32'hDEAD_BEEF);
        read_check("ovf_status", 2'd1, 32'h46);
        read_check("ovf_lastcmd", 2'd0, 32'hDEAD_BEEF);
        check("ovf_head", out_data, 32'hA000_0001);

        // Drain in order.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", {31'd0, out_valid}, 32'd1);
            check("drain_data", out_data, 32'hA000_0000 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", {31'd0, out_valid}, 32'd0);
        read_check("drain_delivered", 2'd3, 32'd4);
        read_check("drain_status", 2'd1, 32'h5);
        bus_write(2'd1, 32'h4);
        read_check("ovf_clear", 2'd1, 32'h1);

        // Push while full with a simultaneous transfer.
        for (int i = 1; i <= 4; i++) bus_write(2'd0, 32'hB0 + 32'(i));
        out_ready = 1'b1;
        bus_write(2'd0, 32'h55);
        out_ready = 1'b0;
        read_check("full_push_xfer", 2'd1, 32'h42);
        exp_words[0] = 32'hB2; exp_words[1] = 32'hB3;
        exp_words[2] = 32'hB4; exp_words[3] = 32'h55;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fx_data", out_data, exp_words[i]);
            step();
        end
        out_ready = 1'b0;
        read_check("fx_delivered", 2'd3, 32'd9);
        bus_write(2'd3, 32'hFFFF_FFFF);
        read_check("deliv_clear", 2'd3, 32'd0);

        // Push and transfer with occupancy 1.
        bus_write(2'd0, 32'hC1);
        out_ready = 1'b1;
        bus_write(2'd0, 32'hC2);
        out_ready = 1'b0;
        check("occ1_valid", {31'd0, out_valid}, 32'd1);
        check("occ1_data", out_data, 32'hC2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        read_check("occ1_delivered", 2'd3, 32'd2);

        // Flush without and with a coincident transfer.
        bus_write(2'd0, 32'h1234_5678);
        bus_write(2'd2, 32'h1);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_data", out_data, 32'd0);
        read_check("flush_status", 2'd1, 32'h1);
        read_check("flush_delivered", 2'd3, 32'd2);
        bus_write(2'd0, 32'h77);
        bus_write(2'd0, 32'h78);
        out_ready = 1'b1;
        bus_write(2'd2, 32'h1);
        out_ready = 1'b0;
        check("flushx_valid", {31'd0, out_valid}, 32'd0);
        read_check("flushx_delivered", 2'd3, 32'd3);

`ifdef SOC_CMD_IRQ_EN
        bus_write(2'd2, 32'h100);
        step();
        check("irq_set", {31'd0, irq}, 32'd1);
        read_check("ctrl_readback", 2'd2, 32'h100);
        bus_write(2'd0, 32'hE1);
        step();
        check("irq_clear", {31'd0, irq}, 32'd0);
        bus_write(2'd2, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`else
        bus_write(2'd2, 32'h300);
        read_check("ctrl_ignored", 2'd2, 32'h0);
`endif

        // Asynchronous reset mid-operation.
        bus_write(2'd0, 32'hF1);
        bus_write(2'd0, 32'hF2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_data", out_data, 32'd0);
        step();
        reset_n = 1'b1;
        read_check("arst_status", 2'd1, 32'h1);
        read_check("arst_delivered", 2'd3, 32'd0);
        read_check("arst_cmd", 2'd0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
